// File: rtl/rv_cache_pkg.sv
// Shared cache-controller types: FSM state encoding and helpers that derive the
// offset/index/tag field widths from the address width and cache geometry.
package rv_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        RESUME = 2'd3
    } cache_state_e;

    // Word-offset field width: one bit per doubling of words per line.
    function automatic int offset_width(input int words);
        return $clog2(words);
    endfunction

    // Line-index field width.
    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is whatever remains of the word address above index and offset.
    function automatic int tag_width(input int addr_w, input int lines, input int words);
        return addr_w - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped cache storage: per-line valid bit and tag plus a flat data
// array addressed by {index, offset}. Reads are asynchronous; writes are a
// single word per clock. Only the valid bits are reset; tag/data are plain
// storage that is never consulted while the line is invalid.
module dcache_array #(
    parameter int DATA_W = 32,
    parameter int LINES  = 32,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 3,
    parameter int IDX_W  = 5,
    parameter int OFF_W  = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_word,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_done,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx
);

    logic [LINES-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_r  [LINES];
    logic [DATA_W-1:0] data_r [LINES*WORDS];

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_word  = data_r[{rd_idx, rd_off}];

    // Valid bits: cleared when a refill starts so a half-filled line can never hit,
    // set only once the final beat of the refill has landed.
    always_ff @(posedge clk) begin
        if (RST) begin
            valid_r <= '0;
        end else begin
            if (inv_en) begin
                valid_r[inv_idx] <= 1'b0;
            end
            if (fill_done) begin
                valid_r[wr_idx] <= 1'b1;
            end
        end
    end

    // Tag capture at refill completion.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_r[wr_idx] <= fill_tag;
        end
    end

    // Single-word data write (refill beat or write-through hit update).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[{wr_idx, wr_off}] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller sitting
// between the core's load/store path and a word-wide memory beat port.
// Optional feature macro: DCACHE_STATS_EN adds hit_cnt/miss_cnt counters.
module dcache_ctrl
    import rv_cache_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LINES  = 32,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W = offset_width(WORDS);
    localparam int IDX_W = index_width(LINES);
    localparam int TAG_W = tag_width(ADDR_W, LINES, WORDS);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    cache_state_e      state_r;
    cache_state_e      next_state_s;

    logic [ADDR_W-1:0] lat_addr_r;
    logic [DATA_W-1:0] lat_data_r;
    logic [OFF_W-1:0]  beat_r;
    logic [OFF_W-1:0]  beat_next_s;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic [ADDR_W-1:0] look_addr_s;
    logic [TAG_W-1:0]  look_tag_s;
    logic [IDX_W-1:0]  look_idx_s;
    logic [OFF_W-1:0]  look_off_s;
    logic [TAG_W-1:0]  lat_tag_s;
    logic [IDX_W-1:0]  lat_idx_s;
    logic [OFF_W-1:0]  lat_off_s;

    logic              rd_valid_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              hit_s;
    logic              beat_ok_s;
    logic              last_beat_s;

    logic              stall_s;
    logic              arr_we_s;
    logic              arr_fill_s;
    logic              arr_inv_s;
    logic [OFF_W-1:0]  arr_woff_s;
    logic [DATA_W-1:0] arr_wdata_s;

    // While idle (or retiring) the core's address drives the lookup; during a
    // memory operation the latched address does.
    always_comb begin
        look_addr_s = lat_addr_r;
        if (state_r == IDLE || state_r == RESUME) begin
            look_addr_s = Addr;
        end else begin
            look_addr_s = lat_addr_r;
        end
    end

    assign look_tag_s  = look_addr_s[ADDR_W-1 -: TAG_W];
    assign look_idx_s  = look_addr_s[OFF_W +: IDX_W];
    assign look_off_s  = look_addr_s[OFF_W-1:0];
    assign lat_tag_s   = lat_addr_r[ADDR_W-1 -: TAG_W];
    assign lat_idx_s   = lat_addr_r[OFF_W +: IDX_W];
    assign lat_off_s   = lat_addr_r[OFF_W-1:0];

    assign hit_s       = rd_valid_s && (rd_tag_s == look_tag_s);
    assign beat_ok_s   = mem_req_r && mem_ready;
    assign last_beat_s = (beat_r == LAST_BEAT);
    assign beat_next_s = beat_r + {{(OFF_W-1){1'b0}}, 1'b1};

    dcache_array #(
        .DATA_W (DATA_W),
        .LINES  (LINES),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W)
    ) u_array (
        .clk       (clk),
        .RST       (RST),
        .rd_idx    (look_idx_s),
        .rd_off    (look_off_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_word   (rd_word_s),
        .wr_en     (arr_we_s),
        .wr_idx    (lat_idx_s),
        .wr_off    (arr_woff_s),
        .wr_data   (arr_wdata_s),
        .fill_done (arr_fill_s),
        .fill_tag  (lat_tag_s),
        .inv_en    (arr_inv_s),
        .inv_idx   (look_idx_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a simultaneous read and write is handled as a write.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (MemWrite) begin
                    next_state_s = WRITE;
                end else if (MemRead && !hit_s) begin
                    next_state_s = REFILL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REFILL: begin
                if (beat_ok_s && last_beat_s) begin
                    next_state_s = RESUME;
                end else begin
                    next_state_s = REFILL;
                end
            end
            WRITE: begin
                if (beat_ok_s) begin
                    next_state_s = RESUME;
                end else begin
                    next_state_s = WRITE;
                end
            end
            RESUME: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM outputs: core stall and the array write/fill/invalidate strobes.
    always_comb begin
        stall_s     = 1'b0;
        arr_we_s    = 1'b0;
        arr_fill_s  = 1'b0;
        arr_inv_s   = 1'b0;
        arr_woff_s  = lat_off_s;
        arr_wdata_s = lat_data_r;
        case (state_r)
            IDLE: begin
                if (MemWrite) begin
                    stall_s = 1'b1;
                end else if (MemRead && !hit_s) begin
                    stall_s   = 1'b1;
                    arr_inv_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            REFILL: begin
                stall_s     = 1'b1;
                arr_we_s    = beat_ok_s;
                arr_woff_s  = beat_r;
                arr_wdata_s = mem_rdata;
                arr_fill_s  = beat_ok_s && last_beat_s;
            end
            WRITE: begin
                stall_s  = 1'b1;
                arr_we_s = beat_ok_s && hit_s;
            end
            RESUME: begin
                stall_s = 1'b0;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Registered memory-port drive, beat counter and the latched access.
    always_ff @(posedge clk) begin
        if (RST) begin
            lat_addr_r  <= '0;
            lat_data_r  <= '0;
            beat_r      <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (MemWrite) begin
                        lat_addr_r  <= Addr;
                        lat_data_r  <= Data_in;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= Addr;
                        mem_wdata_r <= Data_in;
                    end else if (MemRead && !hit_s) begin
                        lat_addr_r <= Addr;
                        beat_r     <= '0;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {Addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (beat_ok_s) begin
                        if (last_beat_s) begin
                            mem_req_r <= 1'b0;
                            beat_r    <= '0;
                        end else begin
                            beat_r     <= beat_next_s;
                            mem_addr_r <= {lat_addr_r[ADDR_W-1:OFF_W], beat_next_s};
                        end
                    end
                end
                WRITE: begin
                    if (beat_ok_s) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                    end
                end
                RESUME: begin
                    mem_req_r <= 1'b0;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = stall_s;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    // Load data is forced to zero unless the current read hits, so no stale or
    // uninitialised array content ever reaches the core.
    always_comb begin
        Data_out = '0;
        if (MemRead && hit_s) begin
            Data_out = rd_word_s;
        end else begin
            Data_out = '0;
        end
    end

`ifdef DCACHE_STATS_EN
    // Hit/miss statistics for reads decided in IDLE (RESUME retirements are not counted).
    always_ff @(posedge clk) begin
        if (RST) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (state_r == IDLE && MemRead && !MemWrite) begin
            if (hit_s) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
